// File: rtl/sync_fifo_pkg.sv
// Shared types, sizing helpers and flag derivation for sync_fifo_pro.
package sync_fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic fifo_flags_t flags_from_count(input int count, input int depth,
                                                    input int af_level, input int ae_level);
      fifo_flags_t f;
      f.full         = (count == depth);
      f.empty        = (count == 0);
      f.almost_full  = (count >= af_level);
      f.almost_empty = (count <= ae_level);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_pro_if.sv
// Producer/consumer bundle for sync_fifo_pro; master = the block driving requests.
interface sync_fifo_pro_if import sync_fifo_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
);
   localparam int AW = clog2(DEPTH);

   logic              clr;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [AW:0]       data_count;
   logic              overflow;
   logic              underflow;

   modport master (
      output clr, wr_en, wr_data, rd_en,
      input  rd_data, full, empty, almost_full, almost_empty, data_count, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, wr_data, rd_en,
      output rd_data, full, empty, almost_full, almost_empty, data_count, overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_pro_ram.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read; contents are never reset.
module fifo_ram import sync_fifo_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int AW     = clog2(DEPTH)
) (
   input  logic              sys_clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DEPTH-1:0][DATA_W-1:0] mem;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_ff @(posedge sys_clk) begin
         if (we && (waddr == AW'(i))) mem[i] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_pro.sv
// Parametrised single-clock FIFO with optional first-word-fall-through, threshold flags,
// error pulses and synchronous flush.
module sync_fifo_pro import sync_fifo_pkg::*; #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 256,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   sync_fifo_pro_if.slave bus
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
      $error("sync_fifo_pro: DEPTH must be a power of two and at least 4");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_pro: AF_LEVEL must lie in 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_pro: AE_LEVEL must lie in 0..DEPTH-1");
   end

   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count_q, count_nxt;
   fifo_flags_t       flags_q, flags_nxt;
   logic              overflow_q, underflow_q;
   logic              rd_acc, wr_acc;
   logic [DATA_W-1:0] ram_rdata;

   // A full FIFO still takes a write when the same cycle pops a word.
   assign rd_acc = bus.rd_en & ~flags_q.empty;
   assign wr_acc = bus.wr_en & (~flags_q.full | rd_acc);

   always_comb begin
      count_nxt = count_q;
      if (bus.clr) begin
         count_nxt = '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
         endcase
      end
      flags_nxt = flags_from_count(int'(count_nxt), DEPTH, AF_LEVEL, AE_LEVEL);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         flags_q     <= FLAGS_RST;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.clr) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         flags_q     <= flags_nxt;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         count_q     <= count_nxt;
         flags_q     <= flags_nxt;
         overflow_q  <= bus.wr_en & flags_q.full & ~rd_acc;
         underflow_q <= bus.rd_en & flags_q.empty;
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .sys_clk (sys_clk),
      .we      (wr_acc & ~bus.clr),
      .waddr   (wr_ptr),
      .wdata   (bus.wr_data),
      .raddr   (rd_ptr),
      .rdata   (ram_rdata)
   );

   if (FWFT != 0) begin : g_fwft
      assign bus.rd_data = ram_rdata;
   end else begin : g_std
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n)  rd_q <= '0;
         else if (bus.clr) rd_q <= '0;
         else if (rd_acc)  rd_q <= ram_rdata;
      end
      assign bus.rd_data = rd_q;
   end

   assign bus.full         = flags_q.full;
   assign bus.empty        = flags_q.empty;
   assign bus.almost_full  = flags_q.almost_full;
   assign bus.almost_empty = flags_q.almost_empty;
   assign bus.data_count   = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Directed bench: 256x8 standard-mode FIFO plus an 8x16 FWFT FIFO on a shared clock/reset.
module tb_sync_fifo_pro;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 sys_clk = ~sys_clk;

   sync_fifo_pro_if #(.DATA_W(8),  .DEPTH(256)) s ();
   sync_fifo_pro_if #(.DATA_W(16), .DEPTH(8))   f ();

   sync_fifo_pro #(.DATA_W(8), .DEPTH(256), .FWFT(0), .AF_LEVEL(252), .AE_LEVEL(4)) u_std (
      .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .bus (s));

   sync_fifo_pro #(.DATA_W(16), .DEPTH(8), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(4)) u_fwft (
      .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .bus (f));

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic s_drive(input logic clr, input logic we, input logic [7:0] wd, input logic re);
      s.clr = clr; s.wr_en = we; s.wr_data = wd; s.rd_en = re;
   endtask

   task automatic f_drive(input logic we, input logic [15:0] wd, input logic re);
      f.clr = 1'b0; f.wr_en = we; f.wr_data = wd; f.rd_en = re;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      s_drive(1'b0, 1'b0, 8'h00, 1'b0);
      f_drive(1'b0, 16'h0000, 1'b0);
      #12;
      n_tests++; if (s.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %0h want 0", s.rd_data); end
      n_tests++; if (s.data_count !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", s.data_count); end
      n_tests++; if (s.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", s.empty); end
      n_tests++; if (s.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b want 1", s.almost_empty); end
      n_tests++; if (s.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", s.full); end
      n_tests++; if (s.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b want 0", s.almost_full); end
      n_tests++; if (s.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", s.overflow); end
      n_tests++; if (s.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", s.underflow); end
      n_tests++; if (f.empty !== 1'b1) begin n_fail++; $display("FAIL reset_fwft_empty: got %b want 1", f.empty); end
      sys_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill(input int base);
      for (int i = 0; i < 256; i++) begin
         s_drive(1'b0, 1'b1, 8'(i + base), 1'b0);
         tick();
         n_tests++; if (s.data_count !== 9'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, s.data_count, i + 1); end
         n_tests++; if (s.almost_full !== (i + 1 >= 252)) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, s.almost_full, (i + 1 >= 252)); end
         n_tests++; if (s.full !== (i + 1 == 256)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, s.full, (i + 1 == 256)); end
      end
      s_drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_overflow();
      s_drive(1'b0, 1'b1, 8'hEE, 1'b0);
      tick();
      n_tests++; if (s.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", s.overflow); end
      n_tests++; if (s.data_count !== 9'd256) begin n_fail++; $display("FAIL ovf_count: got %0d want 256", s.data_count); end
      s_drive(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      n_tests++; if (s.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b want 0", s.overflow); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 256; i++) begin
         s_drive(1'b0, 1'b0, 8'h00, 1'b1);
         tick();
         n_tests++; if (s.rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, s.rd_data, 8'(i)); end
         n_tests++; if (s.data_count !== 9'(255 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, s.data_count, 255 - i); end
         n_tests++; if (s.almost_empty !== (255 - i <= 4)) begin n_fail++; $display("FAIL drain_almost_empty[%0d]: got %b want %b", i, s.almost_empty, (255 - i <= 4)); end
         n_tests++; if (s.empty !== (i == 255)) begin n_fail++; $display("FAIL drain_empty[%0d]: got %b want %b", i, s.empty, (i == 255)); end
      end
   endtask

   task automatic test_underflow();
      s_drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      n_tests++; if (s.underflow !== 1'b1) begin n_fail++; $display("FAIL unf_pulse: got %b want 1", s.underflow); end
      n_tests++; if (s.rd_data !== 8'hFF) begin n_fail++; $display("FAIL unf_rd_hold: got %0h want ff", s.rd_data); end
      n_tests++; if (s.data_count !== 9'd0) begin n_fail++; $display("FAIL unf_count: got %0d want 0", s.data_count); end
      s_drive(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      n_tests++; if (s.underflow !== 1'b0) begin n_fail++; $display("FAIL unf_one_cycle: got %b want 0", s.underflow); end
   endtask

   task automatic test_simul_empty();
      s_drive(1'b0, 1'b1, 8'h5A, 1'b1);
      tick();
      n_tests++; if (s.data_count !== 9'd1) begin n_fail++; $display("FAIL se_count: got %0d want 1", s.data_count); end
      n_tests++; if (s.underflow !== 1'b1) begin n_fail++; $display("FAIL se_underflow: got %b want 1", s.underflow); end
      n_tests++; if (s.empty !== 1'b0) begin n_fail++; $display("FAIL se_empty: got %b want 0", s.empty); end
      n_tests++; if (s.rd_data !== 8'hFF) begin n_fail++; $display("FAIL se_rd_hold: got %0h want ff", s.rd_data); end
      s_drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      n_tests++; if (s.rd_data !== 8'h5A) begin n_fail++; $display("FAIL se_read: got %0h want 5a", s.rd_data); end
      n_tests++; if (s.empty !== 1'b1) begin n_fail++; $display("FAIL se_empty_after: got %b want 1", s.empty); end
      s_drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_simul_full();
      test_fill(0);
      s_drive(1'b0, 1'b1, 8'hC3, 1'b1);
      tick();
      n_tests++; if (s.data_count !== 9'd256) begin n_fail++; $display("FAIL sf_count: got %0d want 256", s.data_count); end
      n_tests++; if (s.overflow !== 1'b0) begin n_fail++; $display("FAIL sf_overflow: got %b want 0", s.overflow); end
      n_tests++; if (s.full !== 1'b1) begin n_fail++; $display("FAIL sf_full: got %b want 1", s.full); end
      n_tests++; if (s.rd_data !== 8'h00) begin n_fail++; $display("FAIL sf_rd0: got %0h want 0", s.rd_data); end
      s_drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      n_tests++; if (s.rd_data !== 8'h01) begin n_fail++; $display("FAIL sf_rd1: got %0h want 1", s.rd_data); end
      n_tests++; if (s.data_count !== 9'd255) begin n_fail++; $display("FAIL sf_count_after: got %0d want 255", s.data_count); end
      s_drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_clr();
      s_drive(1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      for (int i = 0; i < 128; i++) begin
         s_drive(1'b0, 1'b1, 8'(i + 8'h40), 1'b0);
         tick();
      end
      s_drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      n_tests++; if (s.rd_data !== 8'h40) begin n_fail++; $display("FAIL clr_pre_read: got %0h want 40", s.rd_data); end
      n_tests++; if (s.data_count !== 9'd127) begin n_fail++; $display("FAIL clr_pre_count: got %0d want 127", s.data_count); end
      s_drive(1'b1, 1'b1, 8'h99, 1'b1);
      tick();
      n_tests++; if (s.data_count !== 9'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", s.data_count); end
      n_tests++; if (s.empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty: got %b want 1", s.empty); end
      n_tests++; if (s.almost_empty !== 1'b1) begin n_fail++; $display("FAIL clr_almost_empty: got %b want 1", s.almost_empty); end
      n_tests++; if (s.full !== 1'b0) begin n_fail++; $display("FAIL clr_full: got %b want 0", s.full); end
      n_tests++; if (s.rd_data !== 8'h00) begin n_fail++; $display("FAIL clr_rd_data: got %0h want 0", s.rd_data); end
      n_tests++; if (s.overflow !== 1'b0 || s.underflow !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b%b want 00", s.overflow, s.underflow); end
      s_drive(1'b0, 1'b1, 8'h77, 1'b0);
      tick();
      s_drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      n_tests++; if (s.rd_data !== 8'h77) begin n_fail++; $display("FAIL clr_new_word: got %0h want 77", s.rd_data); end
      n_tests++; if (s.empty !== 1'b1) begin n_fail++; $display("FAIL clr_new_empty: got %b want 1", s.empty); end
      s_drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_fwft();
      int exp_k;
      f_drive(1'b1, 16'hA5A5, 1'b0);
      tick();
      n_tests++; if (f.rd_data !== 16'hA5A5) begin n_fail++; $display("FAIL fwft_first: got %0h want a5a5", f.rd_data); end
      n_tests++; if (f.data_count !== 4'd1) begin n_fail++; $display("FAIL fwft_count1: got %0d want 1", f.data_count); end
      f_drive(1'b0, 16'h0000, 1'b1);
      tick();
      n_tests++; if (f.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_empty: got %b want 1", f.empty); end
      for (int k = 0; k < 6; k++) begin
         f_drive(1'b1, 16'(16'h1000 + k), 1'b0);
         tick();
      end
      n_tests++; if (f.data_count !== 4'd6) begin n_fail++; $display("FAIL fwft_count6: got %0d want 6", f.data_count); end
      n_tests++; if (f.almost_full !== 1'b1) begin n_fail++; $display("FAIL fwft_almost_full: got %b want 1", f.almost_full); end
      exp_k = 0;
      for (int j = 0; j < 6; j++) begin
         n_tests++; if (f.rd_data !== 16'(16'h1000 + exp_k)) begin n_fail++; $display("FAIL fwft_wrap_data[%0d]: got %0h want %0h", j, f.rd_data, 16'h1000 + exp_k); end
         f_drive(1'b1, 16'(16'h1006 + j), 1'b1);
         tick();
         exp_k++;
         n_tests++; if (f.data_count !== 4'd6) begin n_fail++; $display("FAIL fwft_wrap_count[%0d]: got %0d want 6", j, f.data_count); end
      end
      for (int j = 0; j < 6; j++) begin
         n_tests++; if (f.rd_data !== 16'(16'h1000 + exp_k)) begin n_fail++; $display("FAIL fwft_drain_data[%0d]: got %0h want %0h", j, f.rd_data, 16'h1000 + exp_k); end
         f_drive(1'b0, 16'h0000, 1'b1);
         tick();
         exp_k++;
      end
      n_tests++; if (f.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_end_empty: got %b want 1", f.empty); end
      f_drive(1'b0, 16'h0000, 1'b0);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         s_drive(1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
         tick();
      end
      n_tests++; if (s.data_count !== 9'd3) begin n_fail++; $display("FAIL ar_pre_count: got %0d want 3", s.data_count); end
      #2;
      sys_rst_n = 1'b0;
      #1;
      n_tests++; if (s.data_count !== 9'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", s.data_count); end
      n_tests++; if (s.empty !== 1'b1) begin n_fail++; $display("FAIL ar_empty: got %b want 1", s.empty); end
      n_tests++; if (s.almost_empty !== 1'b1) begin n_fail++; $display("FAIL ar_almost_empty: got %b want 1", s.almost_empty); end
      n_tests++; if (s.rd_data !== 8'h00) begin n_fail++; $display("FAIL ar_rd_data: got %0h want 0", s.rd_data); end
      n_tests++; if (s.full !== 1'b0 || s.almost_full !== 1'b0) begin n_fail++; $display("FAIL ar_full_flags: got %b%b want 00", s.full, s.almost_full); end
      s_drive(1'b0, 1'b0, 8'h00, 1'b0);
      #2;
      sys_rst_n = 1'b1;
      tick();
      n_tests++; if (s.empty !== 1'b1) begin n_fail++; $display("FAIL ar_post_empty: got %b want 1", s.empty); end
   endtask

   initial begin
      test_reset();
      test_fill(0);
      test_overflow();
      test_drain();
      test_underflow();
      test_simul_empty();
      test_simul_full();
      test_clr();
      test_fwft();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
